// File: rtl/input_port_unit_pkg.sv
// Shared router definitions: output-port codes, flit type codes and flit field helpers.
// Used by input_port_unit and switch_allocator.
package input_port_unit_pkg;

    typedef enum logic [2:0] {
        PORT_LOCAL   = 3'd0,
        PORT_NORTH   = 3'd1,
        PORT_EAST    = 3'd2,
        PORT_SOUTH   = 3'd3,
        PORT_WEST    = 3'd4,
        PORT_NOT_REQ = 3'b111
    } port_e;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } ipu_state_e;

    // Flit type occupies the top FLIT_TYPE_BITS of the flit; destination Y starts at bit 0
    // and destination X sits directly above it.
    localparam int FLIT_TYPE_BITS = 2;
    localparam int DST_Y_LSB      = 0;

    // HEAD and SINGLE both open a packet and carry a destination.
    function automatic logic opens_packet(input flit_type_e t);
        return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
    endfunction

    // TAIL and SINGLE both close a packet.
    function automatic logic closes_packet(input flit_type_e t);
        return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/input_port_unit_fifo.sv
// flit_fifo: small synchronous FIFO with push/pop, full/empty flags and an occupancy count.
// Pushes while full and pops while empty are ignored. Depth must be a power of two.
module flit_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int PTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [PTR_BITS:0]     count
);

    localparam int CW = PTR_BITS + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    // Next pointer/count values; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_BITS'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_BITS'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Control state: pointers and count cleared on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/input_port_unit.sv
// input_port_unit: per-input flit buffer with XY route computation on the head flit.
// Holds one output-port request per packet toward the allocator and pops a flit per ack.
module input_port_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_BITS   = 2,
    parameter int COORD_BITS = 2,
    parameter int CUR_X      = 0,
    parameter int CUR_Y      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_flit,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [2:0]            request,
    input  logic                  ack,
    output logic [DATA_WIDTH-1:0] out_flit,
    output logic [PTR_BITS:0]     occupancy,
    output logic                  err_drop
);

    import input_port_unit_pkg::*;

    localparam logic [COORD_BITS-1:0] CUR_X_C   = COORD_BITS'(CUR_X);
    localparam logic [COORD_BITS-1:0] CUR_Y_C   = COORD_BITS'(CUR_Y);
    localparam int                    DST_X_LSB = DST_Y_LSB + COORD_BITS;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] head_flit;
    flit_type_e            head_type;
    ipu_state_e            state_q, state_d;
    port_e                 route_q, route_d;
    logic                  req_valid;

    // Dimension-order routing: resolve X first, then Y, else deliver locally.
    function automatic port_e xy_route(input logic [COORD_BITS-1:0] dst_x,
                                       input logic [COORD_BITS-1:0] dst_y);
        if (dst_x > CUR_X_C)      return PORT_EAST;
        else if (dst_x < CUR_X_C) return PORT_WEST;
        else if (dst_y > CUR_Y_C) return PORT_NORTH;
        else if (dst_y < CUR_Y_C) return PORT_SOUTH;
        else                      return PORT_LOCAL;
    endfunction

    flit_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .PTR_BITS   (PTR_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (in_flit),
        .pop       (fifo_pop),
        .pop_data  (head_flit),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (occupancy)
    );

    assign head_type = flit_type_e'(head_flit[DATA_WIDTH-1 -: FLIT_TYPE_BITS]);
    // A packet in flight only requests while it has a flit to offer; otherwise it stalls.
    assign req_valid = (state_q == ST_ACTIVE) && !fifo_empty;
    // Stray BODY/TAIL at the head while idle has no route: drop it.
    assign err_drop  = (state_q == ST_IDLE) && !fifo_empty && !opens_packet(head_type);
    assign fifo_push = in_valid & ~fifo_full;
    assign fifo_pop  = (ack & req_valid) | err_drop;
    assign in_ready  = ~fifo_full;
    assign request   = req_valid ? route_q : PORT_NOT_REQ;
    assign out_flit  = head_flit;

    // Packet FSM: latch the route on a head flit, release it when the closing flit is granted.
    always_comb begin
        state_d = state_q;
        route_d = route_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && opens_packet(head_type)) begin
                    route_d = xy_route(head_flit[DST_X_LSB +: COORD_BITS],
                                       head_flit[DST_Y_LSB +: COORD_BITS]);
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (ack && req_valid && closes_packet(head_type)) begin
                    route_d = PORT_NOT_REQ;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                route_d = PORT_NOT_REQ;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and route register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            route_q <= PORT_NOT_REQ;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

endmodule

// File: tb/tb_input_port_unit.sv
// Directed testbench for input_port_unit at router coordinate (1,1).
module tb_input_port_unit;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int PB    = 2;
    localparam int CB    = 2;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_flit;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    request;
    logic          ack;
    logic [DW-1:0] out_flit;
    logic [PB:0]   occupancy;
    logic          err_drop;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    input_port_unit #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .PTR_BITS   (PB),
        .COORD_BITS (CB),
        .CUR_X      (1),
        .CUR_Y      (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .request   (request),
        .ack       (ack),
        .out_flit  (out_flit),
        .occupancy (occupancy),
        .err_drop  (err_drop)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [1:0] x,
                                       input logic [1:0] y, input logic [7:0] tag);
        return {t, 14'd0, tag, 4'd0, x, y};
    endfunction

    logic [1:0]  sx   [5] = '{2'd3, 2'd0, 2'd1, 2'd1, 2'd1};
    logic [1:0]  sy   [5] = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd1};
    int          sexp [5] = '{2, 4, 1, 3, 0};
    logic [31:0] pkt  [4];
    logic [31:0] bp   [5];
    logic [31:0] f, tt;

    initial begin
        rst = 1'b0; in_valid = 1'b0; ack = 1'b0; in_flit = '0;
        step(); step();
        check_eq("rst_request", request, 3'b111);
        check_eq("rst_occ", occupancy, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_err_drop", err_drop, 0);
        rst = 1'b1;
        step(); step();
        check_eq("idle_request", request, 3'b111);
        check_eq("idle_occ", occupancy, 0);

        // Single-flit packets in every direction
        for (int i = 0; i < 5; i++) begin
            f = mk(T_SINGLE, sx[i], sy[i], 8'h10 + 8'(i));
            in_flit = f; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            check_eq($sformatf("single%0d_req_early", i), request, 3'b111);
            check_eq($sformatf("single%0d_occ", i), occupancy, 1);
            step();
            check_eq($sformatf("single%0d_req", i), request, sexp[i]);
            check_eq($sformatf("single%0d_out", i), out_flit, f);
            ack = 1'b1;
            step();
            ack = 1'b0;
            check_eq($sformatf("single%0d_req_done", i), request, 3'b111);
            check_eq($sformatf("single%0d_occ_done", i), occupancy, 0);
        end

        // Four-flit packet, continuous ack
        pkt[0] = mk(T_HEAD, 2'd2, 2'd0, 8'h20);
        pkt[1] = mk(T_BODY, 2'd0, 2'd0, 8'h21);
        pkt[2] = mk(T_BODY, 2'd0, 2'd0, 8'h22);
        pkt[3] = mk(T_TAIL, 2'd0, 2'd0, 8'h23);
        ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                in_flit = pkt[i]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 1 && i <= 4) begin
                check_eq($sformatf("pkt_req%0d", i), request, 2);
                check_eq($sformatf("pkt_out%0d", i), out_flit, pkt[i-1]);
            end
        end
        ack = 1'b0;
        check_eq("pkt_req_end", request, 3'b111);
        check_eq("pkt_occ_end", occupancy, 0);
        check_eq("pkt_err_drop", err_drop, 0);

        // Backpressure: fill with no ack
        bp[0] = mk(T_HEAD, 2'd3, 2'd1, 8'h30);
        for (int i = 1; i < 5; i++) bp[i] = mk(T_BODY, 2'd0, 2'd0, 8'h30 + 8'(i));
        for (int i = 0; i < 5; i++) begin
            in_flit = bp[i]; in_valid = 1'b1;
            step();
            check_eq($sformatf("bp_occ%0d", i), occupancy, (i < 4) ? i + 1 : 4);
            check_eq($sformatf("bp_rdy%0d", i), in_ready, (i < 3) ? 1 : 0);
        end
        check_eq("bp_req", request, 2);
        check_eq("bp_out", out_flit, bp[0]);
        ack = 1'b1;
        in_flit = bp[4];
        step();
        check_eq("bp_pop_full_occ", occupancy, 3);
        check_eq("bp_pop_full_rdy", in_ready, 1);
        check_eq("bp_pop_full_out", out_flit, bp[1]);
        step();
        check_eq("bp_pushpop_occ", occupancy, 3);
        check_eq("bp_pushpop_out", out_flit, bp[2]);
        tt = mk(T_TAIL, 2'd0, 2'd0, 8'h35);
        in_flit = tt;
        step();
        check_eq("bp_pushpop2_occ", occupancy, 3);
        check_eq("bp_pushpop2_out", out_flit, bp[3]);
        in_valid = 1'b0;
        step();
        check_eq("bp_drain_out4", out_flit, bp[4]);
        step();
        check_eq("bp_drain_tail", out_flit, tt);
        check_eq("bp_drain_req", request, 2);
        step();
        check_eq("bp_end_req", request, 3'b111);
        check_eq("bp_end_occ", occupancy, 0);
        ack = 1'b0;

        // Stall mid-packet: HEAD (1,0) -> SOUTH
        in_flit = mk(T_HEAD, 2'd1, 2'd0, 8'h40); in_valid = 1'b1;
        step();
        in_flit = mk(T_BODY, 2'd0, 2'd0, 8'h41);
        step();
        in_valid = 1'b0;
        check_eq("stall_req", request, 3);
        check_eq("stall_occ", occupancy, 2);
        ack = 1'b1;
        step();
        check_eq("stall_req_b", request, 3);
        step();
        check_eq("stall_empty_req", request, 3'b111);
        step();
        check_eq("stall_wait_req", request, 3'b111);
        tt = mk(T_TAIL, 2'd0, 2'd0, 8'h42);
        in_flit = tt; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("stall_resume_req", request, 3);
        check_eq("stall_resume_out", out_flit, tt);
        check_eq("stall_no_drop", err_drop, 0);
        step();
        check_eq("stall_done_req", request, 3'b111);
        check_eq("stall_done_occ", occupancy, 0);
        ack = 1'b0;

        // Stray BODY in IDLE
        in_flit = mk(T_BODY, 2'd3, 2'd3, 8'h50); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("drop_pulse", err_drop, 1);
        check_eq("drop_req", request, 3'b111);
        check_eq("drop_occ", occupancy, 1);
        step();
        check_eq("drop_pulse_end", err_drop, 0);
        check_eq("drop_occ_end", occupancy, 0);
        check_eq("drop_req_end", request, 3'b111);

        // Reset mid-packet
        in_flit = mk(T_HEAD, 2'd3, 2'd1, 8'h60); in_valid = 1'b1;
        step();
        in_flit = mk(T_BODY, 2'd0, 2'd0, 8'h61);
        step();
        in_valid = 1'b0;
        check_eq("mid_req", request, 2);
        check_eq("mid_occ", occupancy, 2);
        #2 rst = 1'b0;
        #1;
        check_eq("async_rst_req", request, 3'b111);
        check_eq("async_rst_occ", occupancy, 0);
        check_eq("async_rst_rdy", in_ready, 1);
        step();
        rst = 1'b1;
        step(); step();
        check_eq("post_rst_req", request, 3'b111);
        check_eq("post_rst_occ", occupancy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
